serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder that computes a + b + cin one bit per clock, LSB first, using a single 1-bit full-adder cell and a registered carry. It is the area-minimal sequential wrapper around the team's 1-bit full-adder cells. It offers a start/done handshake so a controller or datapath sequencer can use it in place of a parallel ripple adder when latency is cheap and area is not.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only in cycles where busy=0
- a  input  WIDTH  operand A, sampled on the accepting edge only
- b  input  WIDTH  operand B, sampled on the accepting edge only
- cin  input  1  carry-in, sampled on the accepting edge only
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; result valid from this cycle on
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  registered carry-out, held with sum

## Operation
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, sum=0, cout=0. All shift registers, the carry register and the counter clear to 0.
- FSM states:
  - IDLE: busy=0, done=0. Goes to RUN when start=1.
  - RUN: busy=1, done=0. Goes to FIN after WIDTH bit-cycles.
  - FIN: busy=0, done=1. Goes to RUN if start=1, otherwise to IDLE.
- Accept (start=1 in IDLE or FIN):
  - load a and b into shift registers A_sr and B_sr
  - carry <= cin
  - bit counter <= 0
  - state <= RUN
- Each RUN cycle:
  - the full-adder cell adds A_sr[0], B_sr[0] and carry
  - A_sr and B_sr shift right by one
  - the sum bit shifts into the MSB of S_sr, so S_sr also shifts right
  - carry <= cell cout
  - counter increments
- On the RUN cycle with counter==WIDTH-1:
  - sum <= final S_sr value, including the bit produced this cycle
  - cout <= cell cout
  - state <= FIN
- start while busy=1: ignored. No queuing and no error flag.
- Operands may change freely after the accepting edge. They are not re-sampled.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). There is no overflow flag; signed interpretation is the consumer's job.
- sum and cout change only at the completion edge or on reset. Partial results in S_sr are never visible on the ports.
- Reset mid-RUN: abort immediately. All outputs return to reset values and the in-flight operation is lost.

## Timing
- start=1 sampled at edge E0 → busy=1 from E0 through edge E0+WIDTH.
- done=1 and the new sum/cout appear in the cycle after E0+WIDTH, i.e. a latency of WIDTH+1 cycles from the accepting cycle to done.
- done is high for exactly one cycle unless start=1 in that FIN cycle. Even then done is still a single cycle, and busy rises next.
- Back-to-back throughput: one result every WIDTH+1 cycles.
- busy and done are never both high.

## Structure
- Shared package: STATE_T enum (IDLE, RUN, FIN) and a CNT_W function returning $clog2(WIDTH).
- Sub-module: one instance of full_adder_df as the bit cell. The carry register, shift registers, counter and FSM stay in serial_adder.

## Test plan
- Reset: assert rst mid-RUN with WIDTH=8 → busy, done, sum and cout all 0 immediately. After release, start with a=3, b=4, cin=0 → done gives sum=7, cout=0.
- Basic: a=0x5A, b=0x33, cin=1 → done exactly 9 cycles after the accepting cycle with sum=0x8E, cout=0. busy is high for exactly 8 cycles.
- Carry-out and wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Ignored start: pulse start with a=0x01, b=0x01 at bit-cycle 3 of an a=0x10, b=0x20 run → a single done with sum=0x30. No second done follows.
- Back-to-back: hold start=1 continuously with new operands on each accepting edge → a done every 9 cycles, each with the correct sum, and busy never overlaps done.
- Randomized: 1000 random a/b/cin at WIDTH=8 and WIDTH=2 → every {cout,sum} matches the golden a+b+cin. Operands are changed randomly while busy to confirm they are not re-sampled.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter-width helper for serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/serial_adder_fa.sv
// full_adder_df: dataflow 1-bit full adder cell; ports a, b, cin in, s, cout out
module full_adder_df (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial a+b+cin; start/a/b/cin in, busy/done/sum/cout registered out
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = cnt_w(WIDTH);
  state_t state;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_nxt;
  logic [CW-1:0] cnt;
  logic carry, s_bit, c_bit, accept;
  full_adder_df fa (.a(a_sr[0]), .b(b_sr[0]), .cin(carry), .s(s_bit), .cout(c_bit));
  assign s_nxt = {s_bit, s_sr[WIDTH-1:1]};
  assign accept = start && state != RUN;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      a_sr <= '0;
      b_sr <= '0;
      s_sr <= '0;
      cnt <= '0;
      carry <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      carry <= cin;
      cnt <= '0;
      state <= RUN;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      s_sr <= s_nxt;
      carry <= c_bit;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        sum <= s_nxt;
        cout <= c_bit;
        state <= FIN;
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      state <= IDLE;
      done <= 1'b0;
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH=8 and WIDTH=2
module tb_serial_adder;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0, sum8;
  logic [1:0] sum2;
  logic busy8, done8, cout8, busy2, done2, cout2;
  int tests = 0, errs = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .start(start), .a(a[1:0]), .b(b[1:0]), .cin(cin),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2));

  logic [8:0] m_pend [2];
  logic [8:0] m_res [2];
  logic m_done [2];
  int m_left [2];

  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        m_left[k] <= 0;
        m_done[k] <= 1'b0;
        m_res[k] <= '0;
        m_pend[k] <= '0;
      end else begin
        m_done[k] <= m_left[k] == 1;
        if (m_left[k] == 1) m_res[k] <= m_pend[k];
        if (m_left[k] > 0) m_left[k] <= m_left[k] - 1;
        else if (start) begin
          m_left[k] <= k ? 2 : 8;
          m_pend[k] <= k ? 9'(a[1:0]) + 9'(b[1:0]) + 9'(cin) : 9'(a) + 9'(b) + 9'(cin);
        end
      end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("busy8", busy8, m_left[0] > 0);
    chk("done8", done8, m_done[0]);
    chk("res8", {cout8, sum8}, m_res[0]);
    chk("overlap8", busy8 & done8, 0);
    chk("busy2", busy2, m_left[1] > 0);
    chk("done2", done2, m_done[1]);
    chk("res2", {cout2, sum2}, m_res[1][2:0]);
    chk("overlap2", busy2 & done2, 0);
  endtask

  task automatic go8(input string nm, input logic [7:0] x, input logic [7:0] y, input logic c,
                     input logic [8:0] exp, input bit keep, input int pulse);
    int n, nb;
    a = x; b = y; cin = c; start = 1'b1;
    n = 0; nb = 0;
    do begin
      tick();
      n++;
      if (busy8) nb++;
      if (!keep && n == 1) start = 1'b0;
      if (n == pulse) begin
        start = 1'b1; a = 8'h01; b = 8'h01;
      end else begin
        if (pulse > 0 && n == pulse + 1) start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
    end while (!done8 && n < 40);
    chk({nm, "_latency"}, n, 9);
    chk({nm, "_busy_cycles"}, nb, 8);
    chk({nm, "_result"}, {cout8, sum8}, exp);
  endtask

  initial begin
    int nd;
    logic [7:0] x, y;
    logic c;
    repeat (3) tick();
    chk("reset_out", {busy8, done8, cout8, sum8}, 0);
    rst = 1'b0;
    tick();
    go8("basic", 8'h5A, 8'h33, 1'b1, 9'h08E, 0, 0);
    go8("wrap", 8'hFF, 8'h01, 1'b0, 9'h100, 0, 0);
    go8("full", 8'hFF, 8'hFF, 1'b1, 9'h1FF, 0, 0);
    a = 8'h55; b = 8'h11; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("midrun_rst", {busy8, done8, cout8, sum8}, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    go8("after_rst", 8'h03, 8'h04, 1'b0, 9'h007, 0, 0);
    go8("ignored", 8'h10, 8'h20, 1'b0, 9'h030, 0, 3);
    nd = 0;
    repeat (12) begin
      tick();
      if (done8) nd++;
    end
    chk("no_second_done", nd, 0);
    go8("b2b", 8'h12, 8'h34, 1'b0, 9'h046, 1, 0);
    go8("b2b", 8'h80, 8'h80, 1'b1, 9'h101, 1, 0);
    go8("b2b", 8'h7F, 8'h00, 1'b1, 9'h080, 1, 0);
    go8("b2b", 8'hC3, 8'h3C, 1'b0, 9'h0FF, 1, 0);
    start = 1'b0;
    repeat (12) tick();
    a = 8'h03; b = 8'h03; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("w2_done", done2, 1);
    chk("w2_result", {cout2, sum2}, 3'h7);
    repeat (10) tick();
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      go8("rand", x, y, c, 9'(x) + 9'(y) + 9'(c), 0, 0);
    end
    start = 1'b0;
    repeat (12) tick();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
